dff_univ_shift_reg: RTL and testbench

//  Parametrised universal register built as WIDTH master-slave D flip-flops.

---
 rtl/dff_univ_shift_reg_pkg.sv | 18 +
 rtl/dff_univ_shift_reg_dff_cell.sv | 20 ++
 rtl/dff_univ_shift_reg.sv | 92 +++++++++
 tb/tb_dff_univ_shift_reg.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dff_univ_shift_reg_pkg.sv
// rtl/dff_univ_shift_reg_pkg.sv - mode encodings and counter width helper for the universal shift register
package dff_univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    // Counter must represent 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/dff_univ_shift_reg_dff_cell.sv
// rtl/dff_univ_shift_reg_dff_cell.sv - 1-bit rising-edge flop with sync reset and enable
module dff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_BIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_univ_shift_reg.sv
// rtl/dff_univ_shift_reg.sv - universal load/shift/rotate register with saturating shift counter
module dff_univ_shift_reg
    import dff_univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic [WIDTH-1:0]              d,
    input  logic                          sin_r,
    input  logic                          sin_l,
    output logic [WIDTH-1:0]              q,
    output logic                          sout_r,
    output logic                          sout_l,
    output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
    output logic                          done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic             cnt_inc;
    logic             cnt_zero;

    always_comb begin
        q_next   = q;
        cnt_inc  = 1'b0;
        cnt_zero = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_next  = {sin_r, q[WIDTH-1:1]};
                cnt_inc = 1'b1;
            end
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], sin_l};
                cnt_inc = 1'b1;
            end
            MODE_LOAD: begin
                q_next   = d;
                cnt_zero = 1'b1;
            end
            MODE_ROTR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                cnt_inc = 1'b1;
            end
            MODE_ROTL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                cnt_inc = 1'b1;
            end
            MODE_CLEAR: begin
                q_next   = '0;
                cnt_zero = 1'b1;
            end
            default: begin
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        dff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (q_next[i]),
            .q   (q[i])
        );
    end

    // Counter saturates so done stays asserted while data keeps moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt <= '0;
        end else if (en) begin
            if (cnt_zero) begin
                shift_cnt <= '0;
            end else if (cnt_inc && shift_cnt != CNT_MAX) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign done   = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_dff_univ_shift_reg.sv
// tb/tb_dff_univ_shift_reg.sv - directed and random checks of dff_univ_shift_reg against an arithmetic model
module tb_dff_univ_shift_reg;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [3:0] shift_cnt;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    int mq = 0;
    int mc = 0;

    dff_univ_shift_reg #(
        .WIDTH   (W),
        .RST_VAL (RSTV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q"}, int'(q), mq);
        chk({tag, "_sout_r"}, int'(sout_r), mq % 2);
        chk({tag, "_sout_l"}, int'(sout_l), mq / 128);
        chk({tag, "_cnt"}, int'(shift_cnt), mc);
        chk({tag, "_done"}, int'(done), (mc == W) ? 1 : 0);
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic sr, input logic sl);
        rst = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        @(posedge clk);
        if (r) begin
            mq = int'(RSTV);
            mc = 0;
        end else if (e) begin
            case (m)
                3'd1: begin mq = mq / 2 + int'(sr) * 128;         mc = (mc < W) ? mc + 1 : W; end
                3'd2: begin mq = (mq * 2) % 256 + int'(sl);       mc = (mc < W) ? mc + 1 : W; end
                3'd3: begin mq = int'(dd);                        mc = 0; end
                3'd4: begin mq = mq / 2 + (mq % 2) * 128;         mc = (mc < W) ? mc + 1 : W; end
                3'd5: begin mq = (mq * 2) % 256 + mq / 128;       mc = (mc < W) ? mc + 1 : W; end
                3'd6: begin mq = 0;                               mc = 0; end
                default: ;
            endcase
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state
        step("rst", 1, 0, 3'd0, 8'h00, 0, 0);
        chk("rst_q_const", int'(q), 'hA5);

        // LOAD 81 then eight rotate-rights
        step("load81", 0, 1, 3'd3, 8'h81, 0, 0);
        for (int i = 0; i < 8; i++) step("rotr", 0, 1, 3'd4, 8'h00, 0, 0);
        chk("rotr_final_q", int'(q), 'h81);
        chk("rotr_final_done", int'(done), 1);

        // SHL x3 with ones, then SHR with zero
        step("load00", 0, 1, 3'd3, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step("shl", 0, 1, 3'd2, 8'h00, 0, 1);
        chk("shl_q07", int'(q), 'h07);
        step("shr", 0, 1, 3'd1, 8'h00, 0, 0);
        chk("shr_q03", int'(q), 'h03);
        chk("shr_cnt4", int'(shift_cnt), 4);

        // Enable low holds everything
        step("loadff", 0, 1, 3'd3, 8'hFF, 0, 0);
        for (int i = 0; i < 5; i++) step("en0", 0, 0, 3'd1, 8'h00, 0, 0);
        chk("en0_qff", int'(q), 'hFF);

        // Saturation then CLEAR
        for (int i = 0; i < 8; i++) step("sat", 0, 1, 3'd1, 8'h00, 0, 0);
        step("sat_extra", 0, 1, 3'd1, 8'h00, 1, 0);
        step("sat_extra", 0, 1, 3'd1, 8'h00, 1, 0);
        chk("sat_q", int'(q), 'hC0);
        chk("sat_cnt", int'(shift_cnt), 8);
        step("clear", 0, 1, 3'd6, 8'h00, 0, 0);
        chk("clear_q", int'(q), 0);

        // Reset beats LOAD; reserved mode holds
        step("rst_vs_load", 1, 1, 3'd3, 8'h3C, 0, 0);
        chk("rst_wins_q", int'(q), 'hA5);
        step("rsvd", 0, 1, 3'd7, 8'h3C, 1, 1);
        step("rsvd", 0, 1, 3'd7, 8'h55, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom),
                 1'($urandom),
                 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
